// File: rtl/async_req_scheduler_pkg.sv
// Shared types and sizing helpers for the asynchronous request scheduler.
//
// Contents:
//   state_t   - grant FSM states (IDLE, GRANT, HOLD)
//   id_w(n)   - width of an index into n request lines ($clog2(n), at least 1)
//   hold_w(h) - width of a counter able to hold 0..h ($clog2(h+1), at least 1)
package async_req_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  function automatic int id_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Kept at least one bit wide so the counter exists even when the hold-off is 0.
  function automatic int hold_w(input int h);
    return (h < 1) ? 1 : $clog2(h + 1);
  endfunction

endpackage

// File: rtl/async_req_scheduler_rr_pick.sv
// Combinational round-robin picker.
//
// Searches the pending vector upward from ptr, wrapping past the top line,
// and reports the first set bit.
//
// Ports:
//   pending   in  N_REQ  candidate events
//   ptr       in  ID_W   index at which the search starts
//   winner_id out ID_W   first pending index at or above ptr (with wrap)
//   any       out 1      at least one pending bit is set
module rr_pick
  import async_req_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]        pending,
  input  logic [id_w(N_REQ)-1:0]  ptr,
  output logic [id_w(N_REQ)-1:0]  winner_id,
  output logic                    any
);

  localparam int ID_W = id_w(N_REQ);

  always_comb begin
    int idx;
    winner_id = '0;
    any       = 1'b0;
    idx       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      // ptr never exceeds N_REQ-1, so one subtraction is enough to wrap.
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!any && pending[idx]) begin
        any       = 1'b1;
        winner_id = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/async_req_scheduler.sv
// Asynchronous request scheduler.
//
// Brings N_REQ asynchronous level requests into the clk domain through a
// two-flop synchronizer, turns rising edges into latched pending events and
// hands them one at a time to a single consumer through a round-robin
// arbiter, with an optional idle hold-off after every accepted grant.
//
// Ports:
//   clk          in  1      clock
//   rst          in  1      synchronous active-high reset
//   en           in  1      synchronizer enable (synchronizer/edge flops hold when low)
//   async_req    in  N_REQ  asynchronous level requests
//   grant_valid  out 1      an event is offered (registered)
//   grant_id     out ID_W   index of the offered event (registered)
//   grant_ready  in  1      consumer accepts the offered event
//   pending      out N_REQ  latched, not yet accepted events
//   overflow     out N_REQ  sticky: an edge arrived while that line was already pending
//   ovf_clr      in  1      clears all overflow bits
module async_req_scheduler
  import async_req_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int HOLDOFF = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [N_REQ-1:0]        async_req,
  output logic                    grant_valid,
  output logic [id_w(N_REQ)-1:0]  grant_id,
  input  logic                    grant_ready,
  output logic [N_REQ-1:0]        pending,
  output logic [N_REQ-1:0]        overflow,
  input  logic                    ovf_clr
);

  localparam int ID_W  = id_w(N_REQ);
  localparam int CNT_W = hold_w(HOLDOFF);

  localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(N_REQ - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

  logic [N_REQ-1:0] sync1_p0, sync2_p1, edge_p2;
  logic [N_REQ-1:0] rise, clr_mask, pend_q, pend_d, ovf_q, ovf_d;
  logic             accept;

  state_t           state_q, state_d;
  logic [ID_W-1:0]  gid_q, gid_d, ptr_q, ptr_d, winner_id;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             any;

  // p0/p1: two-flop synchronizer; p2: previous sync2 value for edge detect
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_p0 <= '0;
      sync2_p1 <= '0;
      edge_p2  <= '0;
    end else if (en) begin
      sync1_p0 <= async_req;
      sync2_p1 <= sync1_p0;
      edge_p2  <= sync2_p1;
    end
  end

  // Pending/overflow update from detected edges and accepted grants
  assign rise   = en ? (sync2_p1 & ~edge_p2) : '0;
  assign accept = grant_valid & grant_ready;

  always_comb begin
    clr_mask = '0;
    if (accept) clr_mask[gid_q] = 1'b1;
  end

  // A rise in the acceptance cycle re-arms the line instead of overflowing it.
  assign pend_d = (pend_q & ~clr_mask) | rise;
  assign ovf_d  = (ovf_clr ? '0 : ovf_q) | (rise & pend_q & ~clr_mask);

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
      ovf_q  <= '0;
    end else begin
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
    end
  end

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_rr_pick (
    .pending   (pend_q),
    .ptr       (ptr_q),
    .winner_id (winner_id),
    .any       (any)
  );

  // Grant FSM: the winner is sampled only in IDLE so later arrivals never
  // disturb an outstanding offer.
  always_comb begin
    state_d = state_q;
    gid_d   = gid_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (any) begin
          gid_d   = winner_id;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (grant_ready) begin
          ptr_d = (gid_q == LAST_ID) ? '0 : gid_q + 1'b1;
          if (HOLDOFF > 0) begin
            state_d = HOLD;
            cnt_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      HOLD: begin
        if (cnt_q == HOLD_LAST) state_d = IDLE;
        else                    cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gid_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gid_q   <= gid_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are straight decodes of flops; grant_ready has no path to them.
  assign grant_valid = (state_q == GRANT);
  assign grant_id    = gid_q;
  assign pending     = pend_q;
  assign overflow    = ovf_q;

endmodule
